// File: rtl/sprite_rom_arbiter_if.sv
// Request/response and ROM-side signals for the two-port sprite ROM arbiter.
// slave = arbiter side, master = requester/ROM environment side.
interface sprite_rom_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 12
) ();
  logic              fixed_prio;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_data;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [15:0]       grant_cnt0;
  logic [15:0]       grant_cnt1;

  modport slave (
    input  fixed_prio, req0_valid, req0_addr, req1_valid, req1_addr, rom_data,
    output req0_ready, resp0_valid, resp0_data, req1_ready, resp1_valid, resp1_data,
           rom_addr, grant_cnt0, grant_cnt1
  );

  modport master (
    output fixed_prio, req0_valid, req0_addr, req1_valid, req1_addr, rom_data,
    input  req0_ready, resp0_valid, resp0_data, req1_ready, resp1_valid, resp1_data,
           rom_addr, grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Two-port arbiter for a shared synchronous-read sprite ROM: per-cycle grant,
// tag pipeline matched to ROM latency, response routing and grant counters.
module sprite_rom_arbiter #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ROM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  sprite_rom_arbiter_if.slave bus
);

  logic              grant0, grant1, accept;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] last_addr_q, addr_d;
  logic [ROM_LAT-1:0] tag_v_q, tag_p_q;
  logic [ROM_LAT:0]   tag_v_shift, tag_p_shift;
  logic              resp_v, resp_p;
  logic              resp0_valid_q, resp1_valid_q;
  logic [DATA_W-1:0] resp0_data_q, resp1_data_q;
  logic [15:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // last_grant_q = 1 means port 1 won last, so port 0 is next under contention
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      if (bus.fixed_prio || last_grant_q) grant0 = 1'b1;
      else                                grant1 = 1'b1;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  assign accept = grant0 | grant1;

  always_comb begin
    addr_d       = last_addr_q;
    last_grant_d = last_grant_q;
    if (grant0) begin
      addr_d       = bus.req0_addr;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      addr_d       = bus.req1_addr;
      last_grant_d = 1'b1;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0 && cnt0_q != '1) cnt0_d = cnt0_q + 16'd1;
    if (grant1 && cnt1_q != '1) cnt1_d = cnt1_q + 16'd1;
  end

  // Shift via concatenation so ROM_LAT = 1 needs no special case
  assign tag_v_shift = {tag_v_q, accept};
  assign tag_p_shift = {tag_p_q, grant1};
  assign resp_v      = tag_v_q[ROM_LAT-1];
  assign resp_p      = tag_p_q[ROM_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q  <= 1'b1;
      last_addr_q   <= '0;
      tag_v_q       <= '0;
      tag_p_q       <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      last_addr_q   <= addr_d;
      tag_v_q       <= tag_v_shift[ROM_LAT-1:0];
      tag_p_q       <= tag_p_shift[ROM_LAT-1:0];
      resp0_valid_q <= resp_v && !resp_p;
      resp1_valid_q <= resp_v && resp_p;
      if (resp_v && !resp_p) resp0_data_q <= bus.rom_data;
      if (resp_v && resp_p)  resp1_data_q <= bus.rom_data;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rom_addr    = addr_d;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp0_data  = resp0_data_q;
  assign bus.resp1_data  = resp1_data_q;
  assign bus.grant_cnt0  = cnt0_q;
  assign bus.grant_cnt1  = cnt1_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one instance with ROM_LAT=1 and one with
// ROM_LAT=3, each fed by a ROM model whose content is addr[11:0] ^ 12'hAB9.
module tb_sprite_rom_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  sprite_rom_arbiter_if #(.ADDR_W(14), .DATA_W(12)) ifa ();
  sprite_rom_arbiter_if #(.ADDR_W(14), .DATA_W(12)) ifb ();

  sprite_rom_arbiter #(.ADDR_W(14), .DATA_W(12), .ROM_LAT(1)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  sprite_rom_arbiter #(.ADDR_W(14), .DATA_W(12), .ROM_LAT(3)) u_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  function automatic logic [11:0] rom_fn(input logic [13:0] a);
    return a[11:0] ^ 12'hAB9;
  endfunction

  logic [11:0] romb_s1, romb_s2;

  always_ff @(posedge clk) begin
    ifa.rom_data <= rom_fn(ifa.rom_addr);
    romb_s1      <= rom_fn(ifb.rom_addr);
    romb_s2      <= romb_s1;
    ifb.rom_data <= romb_s2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [11:0] b_exp [8];
  int pulses;

  initial begin
    n_cmp = 0;
    n_err = 0;
    b_exp = '{12'hBB9, 12'hBB8, 12'hBBB, 12'hBBA, 12'hBBD, 12'hBBC, 12'hBBF, 12'hBBE};
    ifa.fixed_prio = 1'b0; ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    ifa.req0_addr = '0; ifa.req1_addr = '0;
    ifb.fixed_prio = 1'b0; ifb.req0_valid = 1'b0; ifb.req1_valid = 1'b0;
    ifb.req0_addr = '0; ifb.req1_addr = '0;
    reset = 1'b0;
    #2;

    // Reset values
    do_reset();
    chk("rst_resp0v", ifa.resp0_valid, 0);
    chk("rst_resp1v", ifa.resp1_valid, 0);
    chk("rst_resp0d", ifa.resp0_data, 0);
    chk("rst_romaddr", ifa.rom_addr, 0);
    chk("rst_cnt0", ifa.grant_cnt0, 0);
    chk("rst_cnt1", ifa.grant_cnt1, 0);
    chk("rst_rdy0", ifa.req0_ready, 0);

    // Single port 0 read
    ifa.req0_addr = 14'h0005; ifa.req0_valid = 1'b1; #1;
    chk("sp_rdy0", ifa.req0_ready, 1);
    chk("sp_rdy1", ifa.req1_ready, 0);
    chk("sp_romaddr", ifa.rom_addr, 14'h0005);
    step(); ifa.req0_valid = 1'b0;
    chk("sp_early", ifa.resp0_valid, 0);
    step();
    chk("sp_resp0v", ifa.resp0_valid, 1);
    chk("sp_resp0d", ifa.resp0_data, 12'hABC);
    chk("sp_resp1v", ifa.resp1_valid, 0);
    step();
    chk("sp_once", ifa.resp0_valid, 0);
    chk("sp_cnt0", ifa.grant_cnt0, 1);
    chk("sp_hold", ifa.rom_addr, 14'h0005);

    // Round-robin contention
    do_reset();
    ifa.req0_addr = 14'h0010; ifa.req1_addr = 14'h0020;
    for (int j = 0; j < 6; j++) begin
      ifa.req0_valid = (j < 4); ifa.req1_valid = (j < 4); #1;
      if (j < 4) begin
        chk("rr_rdy0", ifa.req0_ready, (j % 2 == 0));
        chk("rr_rdy1", ifa.req1_ready, (j % 2 == 1));
        chk("rr_addr", ifa.rom_addr, (j % 2 == 0) ? 14'h0010 : 14'h0020);
      end
      if (j >= 2) begin
        chk("rr_resp0v", ifa.resp0_valid, ((j - 2) % 2 == 0));
        chk("rr_resp1v", ifa.resp1_valid, ((j - 2) % 2 == 1));
        if ((j - 2) % 2 == 0) chk("rr_resp0d", ifa.resp0_data, 12'hAA9);
        else                  chk("rr_resp1d", ifa.resp1_data, 12'hA99);
      end else begin
        chk("rr_idle", ifa.resp0_valid | ifa.resp1_valid, 0);
      end
      step();
    end
    chk("rr_cnt0", ifa.grant_cnt0, 2);
    chk("rr_cnt1", ifa.grant_cnt1, 2);

    // Fixed priority
    ifa.fixed_prio = 1'b1; ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_rdy0", ifa.req0_ready, 1);
      chk("fp_rdy1", ifa.req1_ready, 0);
      step();
    end
    ifa.req0_valid = 1'b0; #1;
    chk("fp_drop_rdy1", ifa.req1_ready, 1);
    chk("fp_drop_addr", ifa.rom_addr, 14'h0020);
    step();
    ifa.req1_valid = 1'b0; ifa.fixed_prio = 1'b0;
    step(); step(); step();
    chk("fp_cnt0", ifa.grant_cnt0, 5);
    chk("fp_cnt1", ifa.grant_cnt1, 3);

    // Reset pulse between edges while a port 1 read is in flight
    ifa.req1_addr = 14'h0033; ifa.req1_valid = 1'b1; #1;
    chk("rm_rdy1", ifa.req1_ready, 1);
    step();
    ifa.req1_valid = 1'b0;
    reset = 1'b1; #1;
    chk("rm_romaddr", ifa.rom_addr, 0);
    chk("rm_cnt1", ifa.grant_cnt1, 0);
    chk("rm_resp0d", ifa.resp0_data, 0);
    #1 reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (ifa.resp1_valid) pulses++;
    end
    chk("rm_pulses", pulses, 0);
    chk("rm_resp1d", ifa.resp1_data, 0);

    // ROM_LAT=3 streaming on instance b
    do_reset();
    for (int j = 0; j < 14; j++) begin
      ifb.req0_valid = (j < 8);
      ifb.req0_addr  = 14'h0100 + 14'(j);
      #1;
      if (j < 8) chk("l3_rdy0", ifb.req0_ready, 1);
      if (j >= 4 && j < 12) begin
        chk("l3_resp0v", ifb.resp0_valid, 1);
        chk("l3_resp0d", ifb.resp0_data, b_exp[j - 4]);
      end else begin
        chk("l3_idle", ifb.resp0_valid, 0);
      end
      chk("l3_resp1v", ifb.resp1_valid, 0);
      step();
    end
    chk("l3_cnt0", ifb.grant_cnt0, 8);
    chk("l3_cnt1", ifb.grant_cnt1, 0);

    // Counter saturation
    do_reset();
    ifa.req0_addr = '0; ifa.req0_valid = 1'b1;
    repeat (65534) step();
    chk("sat_pre", ifa.grant_cnt0, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sat_cnt0", ifa.grant_cnt0, 16'hFFFF);
    end
    ifa.req0_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
